uart_tx_arbiter: RTL

Shares the UART peripheral's transmit path between several byte producers (e.g. core debug print, boot loader, trace unit). It arbitrates requesters round-robin into a small FIFO, then drains the FIFO by polling the UART STATUS register and writing TX_REG whenever the transmitter is idle. It sits between the requesters and the UART's register write/read port, and is the only master of that port.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-register-side signals of uart_tx_arbiter.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
//   req_valid_i / req_data_i / req_ready_o : per-requester byte handshake
//   bus_wr_*_o / bus_rd_*_o / bus_rd_data_i : UART register port
//   fifo_level_o / busy_o                   : status
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + UART register file)
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4
);
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [8*NUM_REQ-1:0]         req_data_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic                         bus_wr_en_o;
    logic [31:0]                  bus_wr_addr_o;
    logic [31:0]                  bus_wr_data_o;
    logic                         bus_rd_en_o;
    logic [31:0]                  bus_rd_addr_o;
    logic [31:0]                  bus_rd_data_i;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level_o;
    logic                         busy_o;

    modport slave (
        input  req_valid_i, req_data_i, bus_rd_data_i,
        output req_ready_o, bus_wr_en_o, bus_wr_addr_o, bus_wr_data_o,
               bus_rd_en_o, bus_rd_addr_o, fifo_level_o, busy_o
    );

    modport master (
        output req_valid_i, req_data_i, bus_rd_data_i,
        input  req_ready_o, bus_wr_en_o, bus_wr_addr_o, bus_wr_data_o,
               bus_rd_en_o, bus_rd_addr_o, fifo_level_o, busy_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART transmit path between NUM_REQ byte
// producers. Requesters are arbitrated round-robin into a byte FIFO; the FIFO
// is drained by polling UART STATUS and writing TX_REG while TX is idle. After
// every reset the UART CTRL register is written once to enable TX.
// Ports:
//   clk_i  - single clock, rising edge
//   rst_i  - synchronous active-high reset
//   io     - uart_tx_arbiter_if.slave: requester handshake, UART register
//            read/write port, fifo_level_o and busy_o status
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_GAP   = 8,
    parameter logic [31:0] UART_BASE  = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    uart_tx_arbiter_if.slave    io
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [31:0] ADDR_CTRL   = UART_BASE + 32'h00;
    localparam logic [31:0] ADDR_STATUS = UART_BASE + 32'h04;
    localparam logic [31:0] ADDR_TX     = UART_BASE + 32'h0C;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_BACKOFF,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [7:0]          mem_d [FIFO_DEPTH];

    logic                fifo_full;
    logic                fifo_empty;
    logic                can_accept;
    logic                grant_valid;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      idx;
    logic                push;
    logic                pop;
    logic [7:0]          push_byte;
    logic [7:0]          head_byte;
    logic                unused_rd_bits;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign can_accept = !fifo_full && (state_q != S_INIT) && !rst_i;
    assign push       = grant_valid && can_accept;
    assign pop        = (state_q == S_WRITE);
    assign push_byte  = io.req_data_i[{grant_idx, 3'b000} +: 8];
    assign head_byte  = mem_q[rd_ptr_q];

    // Only STATUS bit 0 (TX busy) is meaningful here.
    assign unused_rd_bits = ^io.bus_rd_data_i[31:1];

    // Round-robin: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                idx = idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_valid && io.req_valid_i[idx[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    // Byte FIFO; fullness comes from the registered count, so a pop in the
    // same cycle never makes room for a push.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_byte;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            S_INIT:    state_d = S_IDLE;
            S_IDLE:    if (!fifo_empty) state_d = S_RD_REQ;
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (io.bus_rd_data_i[0]) begin
                    state_d = S_BACKOFF;
                    gap_d   = GAP_W'(POLL_GAP - 1);
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_BACKOFF: begin
                if (gap_q == '0) begin
                    state_d = S_RD_REQ;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_WRITE:   state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_INIT;
            gap_q    <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Outputs are decoded from state and FIFO head; rst_i masks them so the
    // CTRL write and busy indication only appear once reset is released.
    always_comb begin
        io.req_ready_o   = '0;
        io.bus_wr_en_o   = 1'b0;
        io.bus_wr_addr_o = '0;
        io.bus_wr_data_o = '0;
        io.bus_rd_en_o   = 1'b0;
        io.bus_rd_addr_o = '0;
        io.busy_o        = 1'b0;
        if (!rst_i) begin
            if (push) begin
                io.req_ready_o[grant_idx] = 1'b1;
            end
            io.busy_o = !fifo_empty || (state_q != S_IDLE);
            case (state_q)
                S_INIT: begin
                    io.bus_wr_en_o   = 1'b1;
                    io.bus_wr_addr_o = ADDR_CTRL;
                    io.bus_wr_data_o = 32'h1;
                end
                S_RD_REQ: begin
                    io.bus_rd_en_o   = 1'b1;
                    io.bus_rd_addr_o = ADDR_STATUS;
                end
                S_WRITE: begin
                    io.bus_wr_en_o   = 1'b1;
                    io.bus_wr_addr_o = ADDR_TX;
                    io.bus_wr_data_o = {24'h0, head_byte};
                end
                default: ;
            endcase
        end
    end

    assign io.fifo_level_o = count_q;

endmodule
